instruction_fetch: RTL and testbench

- Fetch stage directly downstream of the instruction pointer.
- Issues in-order instruction reads to memory at the current PC and pulses `incr` back to the pointer for each accepted request.
- Holds fetched words with their addresses in a small reservation buffer and presents them to decode through a valid/ready handshake.
- On a redirect (flush), it discards buffered words and any in-flight responses.

---
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bundle of the pointer, memory and decode-facing signals of the fetch stage.
// The master side is the fetch block; the slave side is its environment.
interface instruction_fetch_if #(
    parameter int bits = 32
);
    logic [bits-1:0] pc;
    logic            incr;
    logic            flush;
    logic            mem_req;
    logic [bits-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [bits-1:0] mem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [bits-1:0] inst_data;
    logic [bits-1:0] inst_addr;

    // Handshakes: a memory request transfers on mem_req && mem_gnt; an instruction
    // transfers to decode on inst_valid && inst_ready. A valid never depends on its ready.
    modport master (
        input  pc, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        output incr, mem_req, mem_addr, inst_valid, inst_data, inst_addr
    );

    modport slave (
        output pc, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        input  incr, mem_req, mem_addr, inst_valid, inst_data, inst_addr
    );
endinterface

// File: rtl/instruction_fetch.sv
// In-order instruction fetch with a small reservation buffer between memory and decode.
// Redirects free the buffer and count still-outstanding responses so they can be discarded.
module instruction_fetch #(
    parameter int bits  = 32,
    parameter int isize = 2,
    parameter int depth = 2
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;
    localparam int DW = $clog2(depth + 1);
    localparam logic [bits-1:0] ALIGN_MASK = ~((bits'(1) << isize) - bits'(1));

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_RSVD = 2'd1,
        SLOT_FILL = 2'd2
    } slot_e;

    slot_e           slot_q [depth];
    slot_e           slot_d [depth];
    logic [bits-1:0] addr_q [depth];
    logic [bits-1:0] addr_d [depth];
    logic [bits-1:0] data_q [depth];
    logic [bits-1:0] data_d [depth];
    logic [IW-1:0]   head_q, head_d;
    logic [IW-1:0]   tail_q, tail_d;
    logic [IW-1:0]   fill_q, fill_d;
    logic [DW-1:0]   drop_q, drop_d;

    logic [DW-1:0]   rsv_cnt;
    logic [DW-1:0]   occ_cnt;
    logic [bits-1:0] aligned_pc;
    logic            req;
    logic            grant;
    logic            pop;
    logic            resp_drop;
    logic            resp_live;
    logic [DW:0]     flush_drop;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        if (p == IW'(depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        rsv_cnt = '0;
        occ_cnt = '0;
        for (int i = 0; i < depth; i++) begin
            if (slot_q[i] == SLOT_RSVD) begin
                rsv_cnt = rsv_cnt + 1'b1;
            end
            if (slot_q[i] != SLOT_FREE) begin
                occ_cnt = occ_cnt + 1'b1;
            end
        end
    end

    assign aligned_pc     = bus.pc & ALIGN_MASK;
    assign req            = !rst && !bus.flush && (occ_cnt < DW'(depth));
    assign grant          = req && bus.mem_gnt;
    assign bus.mem_req    = req;
    assign bus.mem_addr   = aligned_pc;
    assign bus.incr       = grant;
    assign bus.inst_valid = !rst && (slot_q[head_q] == SLOT_FILL);
    assign bus.inst_data  = data_q[head_q];
    assign bus.inst_addr  = addr_q[head_q];

    assign pop       = bus.inst_valid && bus.inst_ready;
    assign resp_drop = bus.mem_rvalid && (drop_q != '0);
    // A response with nothing reserved and nothing to drop is a protocol error and is ignored.
    assign resp_live = bus.mem_rvalid && (drop_q == '0) && (rsv_cnt != '0);

    // Every slot reserved before the redirect still has a response coming, minus one
    // if that response is arriving right now.
    assign flush_drop = {1'b0, drop_q} + {1'b0, rsv_cnt}
                      - (DW + 1)'(resp_drop || resp_live);

    always_comb begin
        slot_d = slot_q;
        addr_d = addr_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        drop_d = drop_q;

        if (bus.flush) begin
            for (int i = 0; i < depth; i++) begin
                slot_d[i] = SLOT_FREE;
            end
            head_d = '0;
            tail_d = '0;
            fill_d = '0;
            // Saturates only if a second redirect lands before earlier drops drain.
            if (flush_drop > (DW + 1)'(depth)) begin
                drop_d = DW'(depth);
            end else begin
                drop_d = flush_drop[DW-1:0];
            end
        end else begin
            if (pop) begin
                slot_d[head_q] = SLOT_FREE;
                head_d         = wrap_inc(head_q);
            end
            if (grant) begin
                slot_d[tail_q] = SLOT_RSVD;
                addr_d[tail_q] = aligned_pc;
                tail_d         = wrap_inc(tail_q);
            end
            if (resp_live) begin
                slot_d[fill_q] = SLOT_FILL;
                data_d[fill_q] = bus.mem_rdata;
                fill_d         = wrap_inc(fill_q);
            end
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                slot_q[i] <= SLOT_FREE;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                slot_q[i] <= slot_d[i];
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
            drop_q <= drop_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic,
// compared against a queue-based model of the buffer, the drop count and an in-order memory.
module tb_instruction_fetch;
    localparam int BITS  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if #(.bits(BITS)) bus ();

    instruction_fetch #(.bits(BITS), .isize(2), .depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [BITS-1:0] addr;
        logic [BITS-1:0] data;
        bit              filled;
    } ent_t;

    typedef struct {
        logic [BITS-1:0] data;
        int              due;
    } mresp_t;

    ent_t            exp_q[$];
    mresp_t          mem_q[$];
    int              drop_n;
    int              cyc;
    int              lat_max;
    int              incr_seen;
    int              n_checks;
    int              n_fail;
    logic [BITS-1:0] pc_r;

    task automatic check(input string tag, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst            = 1'b1;
            bus.mem_gnt    = 1'b1;
            bus.flush      = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            bus.inst_ready = 1'b0;
            pc_r           = '0;
            bus.pc         = '0;
            #1;
            check("rst_mem_req", {31'b0, bus.mem_req}, 0);
            check("rst_incr", {31'b0, bus.incr}, 0);
            check("rst_inst_valid", {31'b0, bus.inst_valid}, 0);
            if (i > 0) begin
                check("rst_inst_data", bus.inst_data, 0);
                check("rst_inst_addr", bus.inst_addr, 0);
            end
        end
        exp_q.delete();
        mem_q.delete();
        drop_n = 0;
    endtask

    task automatic step(input bit fl, input bit gnt, input bit rdy, input bit rv_en,
                        input bit spurious, input logic [BITS-1:0] jump);
        int rsv;
        bit exp_req;
        bit exp_valid;
        bit rv_q;
        @(negedge clk);
        rst            = 1'b0;
        bus.pc         = pc_r;
        bus.flush      = fl;
        bus.mem_gnt    = gnt;
        bus.inst_ready = rdy;
        rv_q           = rv_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.mem_rvalid = rv_q || (spurious && (mem_q.size() == 0));
        bus.mem_rdata  = rv_q ? mem_q[0].data : $urandom();
        #1;
        exp_req   = !fl && (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() > 0) && exp_q[0].filled;
        check("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
        check("incr", {31'b0, bus.incr}, {31'b0, exp_req && gnt});
        check("mem_addr", bus.mem_addr, pc_r & ~32'h3);
        check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("inst_addr", bus.inst_addr, exp_q[0].addr);
            check("inst_data", bus.inst_data, exp_q[0].data);
        end

        rsv = 0;
        foreach (exp_q[i]) if (!exp_q[i].filled) rsv++;
        if (fl) begin
            if (bus.mem_rvalid && (drop_n > 0 || rsv > 0)) drop_n = drop_n + rsv - 1;
            else drop_n = drop_n + rsv;
            exp_q.delete();
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (bus.mem_rvalid) begin
                if (drop_n > 0) begin
                    drop_n--;
                end else begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!exp_q[i].filled) begin
                            exp_q[i].filled = 1'b1;
                            exp_q[i].data   = bus.mem_rdata;
                            break;
                        end
                    end
                end
            end
            if (exp_req && gnt) exp_q.push_back('{pc_r & ~32'h3, '0, 1'b0});
        end

        if (rv_q) void'(mem_q.pop_front());
        if (bus.mem_req && gnt) begin
            mem_q.push_back('{$urandom(), cyc + 1 + $urandom_range(0, lat_max)});
            incr_seen++;
        end
        if (fl) pc_r = jump;
        else if (bus.incr) pc_r = pc_r + 4;
        cyc++;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        drop_n         = 0;
        lat_max        = 0;
        incr_seen      = 0;
        pc_r           = '0;
        rst            = 1'b1;
        bus.pc         = '0;
        bus.flush      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.inst_ready = 1'b0;

        // Reset, then streaming from 0x0 with one-cycle memory latency.
        do_reset(3);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 0, '0);

        // Backpressure: only two grants fit, then drain.
        do_reset(1);
        incr_seen = 0;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, '0);
        check("bp_grants", 32'(incr_seen), 32'd2);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, '0);

        // Grant stall at 0x10.
        do_reset(1);
        step(1, 0, 1, 1, 0, 32'h10);
        incr_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, '0);
        check("stall_no_incr", 32'(incr_seen), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, '0);

        // Flush with two outstanding requests, redirect to 0x100.
        do_reset(1);
        step(0, 1, 1, 0, 0, '0);
        step(0, 1, 1, 0, 0, '0);
        step(1, 1, 1, 0, 0, 32'h100);
        check("flush_drop_cnt", 32'(drop_n), 32'd2);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, '0);

        // Flush coincident with a response.
        do_reset(1);
        step(0, 1, 1, 0, 0, '0);
        step(0, 1, 1, 0, 0, '0);
        step(1, 1, 1, 1, 0, 32'h200);
        check("flush_rv_drop_cnt", 32'(drop_n), 32'd1);
        check("flush_rv_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, '0);

        // Spurious response with an empty buffer is ignored.
        do_reset(1);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);
        step(0, 1, 1, 1, 0, '0);
        step(0, 1, 1, 1, 0, '0);

        // Randomized traffic with variable latency, redirects and occasional resets.
        lat_max = 3;
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                step((drop_n == 0) && ($urandom_range(0, 19) == 0),
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 49) == 0,
                     $urandom());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
